// File: rtl/mux_pkg.sv
// Shared select encoding and width limits for the 4:1 mux family.
// Imported by the combinational core, the registered top and the bench interface.
package mux_pkg;

  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_D = 2'b11
  } sel_e;

  localparam int MUX_MAX_WIDTH = 64;

  // s1 is the select MSB, s2 the LSB.
  function automatic sel_e mux_sel(input logic s1, input logic s2);
    return sel_e'({s1, s2});
  endfunction

endpackage

// File: rtl/full_inf.sv
// Signal bundle for the mux_4to1 verification environment.
// Carries clock, reset, data, select and registered output at matching widths.
interface full_inf #(
  parameter int WIDTH = 1
);
  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] y;
endinterface

// File: rtl/mux4to1_core.sv
// Purely combinational 4:1 select; also used standalone by unregistered users.
// An unknown select yields X so undriven selects show up in simulation.
module mux4to1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_e             sel,
  output logic [WIDTH-1:0] y_next
);

  always_comb begin
    y_next = 'x;
    case (sel)
      SEL_A:   y_next = a;
      SEL_B:   y_next = b;
      SEL_C:   y_next = c;
      SEL_D:   y_next = d;
      default: y_next = 'x;
    endcase
  end

endmodule

// File: rtl/mux_4to1.sv
// Registered 4:1 mux: output reflects the selection sampled on the previous edge.
// Synchronous active-high reset clears the output and takes priority over data.
module mux_4to1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] y
);

  if (WIDTH < 1 || WIDTH > MUX_MAX_WIDTH) begin : g_bad_width
    $error("mux_4to1: WIDTH %0d outside 1..%0d", WIDTH, MUX_MAX_WIDTH);
  end

  sel_e             w_sel;
  logic [WIDTH-1:0] w_y_next;
  logic [WIDTH-1:0] r_y;

  assign w_sel = mux_sel(s1, s2);

  mux4to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .sel    (w_sel),
    .y_next (w_y_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_y <= '0;
    else     r_y <= w_y_next;
  end

  assign y = r_y;

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1 (WIDTH=8) driven through the full_inf bundle.
// A behavioural model picks from an array of the previous cycle's inputs.
module tb_mux_4to1;
  localparam int W     = 8;
  localparam int N_GEN = 10;

  full_inf #(.WIDTH(W)) bus ();

  mux_4to1 #(.WIDTH(W)) dut (
    .clk (bus.clk),
    .rst (bus.rst),
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .d   (bus.d),
    .s1  (bus.s1),
    .s2  (bus.s2),
    .y   (bus.y)
  );

  int errors = 0;
  int checks = 0;

  initial begin
    bus.clk = 1'b0;
    forever #5 bus.clk = ~bus.clk;
  end

  // Reference model: expected y after each edge.
  logic [W-1:0] exp_y;
  bit           seen_rst    = 1'b0;
  bit           model_valid = 1'b0;

  always @(posedge bus.clk) begin
    logic [W-1:0] src [4];
    src[0] = bus.a;
    src[1] = bus.b;
    src[2] = bus.c;
    src[3] = bus.d;
    if (bus.rst) seen_rst = 1'b1;
    if (bus.rst) exp_y = '0;
    else         exp_y = src[int'(bus.s1) * 2 + int'(bus.s2)];
    model_valid = seen_rst;
  end

  always @(negedge bus.clk) begin
    if (model_valid) begin
      checks++;
      if (bus.y !== exp_y) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t y=%h expected=%h", $time, bus.y, exp_y);
      end
    end
  end

  task automatic cyc(input logic [W-1:0] a, b, c, d, input logic [1:0] sel, input logic rst);
    bus.a   = a;
    bus.b   = b;
    bus.c   = c;
    bus.d   = d;
    bus.s1  = sel[1];
    bus.s2  = sel[0];
    bus.rst = rst;
    @(negedge bus.clk);
  endtask

  task automatic lit(input string name, input logic [W-1:0] want);
    checks++;
    if (bus.y !== want) begin
      errors++;
      $display("FAIL %s y=%h expected=%h", name, bus.y, want);
    end
    checks++;
    if (exp_y !== want) begin
      errors++;
      $display("FAIL %s_model model=%h expected=%h", name, exp_y, want);
    end
  endtask

  initial begin
    // Reset held for two edges with every input at 1 and sel=11.
    cyc(8'h01, 8'h01, 8'h01, 8'h01, 2'b11, 1'b1);
    lit("reset_1", 8'h00);
    cyc(8'h01, 8'h01, 8'h01, 8'h01, 2'b11, 1'b1);
    lit("reset_2", 8'h00);
    cyc(8'h01, 8'h01, 8'h01, 8'h01, 2'b11, 1'b0);
    lit("reset_release", 8'h01);

    // Select sweep.
    cyc(8'h01, 8'h00, 8'h01, 8'h00, 2'b00, 1'b0);
    lit("sweep_00", 8'h01);
    cyc(8'h01, 8'h00, 8'h01, 8'h00, 2'b01, 1'b0);
    lit("sweep_01", 8'h00);
    cyc(8'h01, 8'h00, 8'h01, 8'h00, 2'b10, 1'b0);
    lit("sweep_10", 8'h01);
    cyc(8'h01, 8'h00, 8'h01, 8'h00, 2'b11, 1'b0);
    lit("sweep_11", 8'h00);

    // Unselected inputs toggle; output must hold c.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] t;
      t = (i % 2 == 0) ? 8'hFF : 8'h00;
      cyc(t, ~t, 8'h01, t, 2'b10, 1'b0);
      lit("isolation", 8'h01);
    end

    // Wide data.
    cyc(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b01, 1'b0);
    lit("wide_sel01", 8'h3C);
    cyc(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b11, 1'b0);
    lit("wide_sel11", 8'h00);
    cyc(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b10, 1'b0);
    lit("wide_sel10", 8'hFF);

    // Mid-stream reset.
    cyc(8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
    lit("stream_1", 8'h01);
    cyc(8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
    lit("stream_2", 8'h01);
    cyc(8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);
    lit("midreset", 8'h00);
    cyc(8'h01, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
    lit("midreset_release", 8'h01);

    // Simultaneous select and data change.
    cyc(8'h11, 8'h22, 8'h33, 8'h44, 2'b00, 1'b0);
    lit("simul_a", 8'h11);
    cyc(8'h11, 8'h22, 8'h33, 8'h9E, 2'b11, 1'b0);
    lit("simul_d", 8'h9E);

    // Randomized transactions; the model checks each cycle.
    for (int i = 0; i < N_GEN; i++)
      cyc(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
          2'($urandom_range(0, 3)), 1'b0);

    // Longer random run with occasional resets.
    for (int i = 0; i < 200; i++)
      cyc(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
          2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));

    @(posedge bus.clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
